// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline registers: the NOP/bubble encoding,
// the default reset PC and the IF/ID payload layout.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{
    instr:    NOP_INSTR,
    pc:       32'h0000_0000,
    pc_plus4: 32'h0000_0000,
    valid:    1'b0
  };

  // A bubble still carries the PC it replaced so later stages can trace it.
  function automatic ifid_t ifid_bubble(input logic [31:0] pc,
                                        input logic [31:0] pc_plus4);
    ifid_t b;
    b.instr    = NOP_INSTR;
    b.pc       = pc;
    b.pc_plus4 = pc_plus4;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with its next-PC mux: redirect beats stall beats increment.
// Updates on the falling edge like the rest of the pipeline registers.
module pc_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] PCF
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (PCSrcE) begin
      // Targets are word aligned; low bits from EX are discarded.
      w_pc_next = {PCTargetE[31:2], 2'b00};
    end else if (stallF) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign PCF = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register plus the IF/ID pipeline register.
// validD marks a real instruction; stallD/flushD/PCSrcE act as backpressure and kill, there is no ready.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] PCPlus4D,
  output logic        validD
);

  logic [31:0] w_pcf;
  logic [31:0] w_pc_plus4_f;
  ifid_t       r_ifid;
  ifid_t       w_ifid_next;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .stallF    (stallF),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .PCF       (w_pcf)
  );

  assign w_pc_plus4_f = w_pcf + 32'd4;
  assign imem_addr    = w_pcf;

  // A redirect squashes whatever is being fetched, so it bubbles IF/ID like a flush.
  always_comb begin
    w_ifid_next = r_ifid;
    if (flushD || PCSrcE) begin
      w_ifid_next = ifid_bubble(w_pcf, w_pc_plus4_f);
    end else if (!stallD) begin
      w_ifid_next.instr    = imem_rdata;
      w_ifid_next.pc       = w_pcf;
      w_ifid_next.pc_plus4 = w_pc_plus4_f;
      w_ifid_next.valid    = 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_ifid <= IFID_RESET;
    end else begin
      r_ifid <= w_ifid_next;
    end
  end

  assign instrD   = r_ifid.instr;
  assign pcD      = r_ifid.pc;
  assign PCPlus4D = r_ifid.pc_plus4;
  assign validD   = r_ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: ROM returns its own address, expected IF/ID
// state is queued when each step is driven and checked after the falling edge.
module tb_fetch_stage;

  localparam int W = 129;

  logic        clk;
  logic        rst;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] PCPlus4D;
  logic        validD;

  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic [31:0] instrD2;
  logic [31:0] pcD2;
  logic [31:0] PCPlus4D2;
  logic        validD2;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  assign imem_rdata  = imem_addr;
  assign imem_rdata2 = imem_addr2;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .pcD        (pcD),
    .PCPlus4D   (PCPlus4D),
    .validD     (validD)
  );

  fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_addr  (imem_addr2),
    .imem_rdata (imem_rdata2),
    .instrD     (instrD2),
    .pcD        (pcD2),
    .PCPlus4D   (PCPlus4D2),
    .validD     (validD2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pcf"},    imem_addr,     32'h0000_0000);
    check({tag, ".instr"},  instrD,        32'h0000_0013);
    check({tag, ".pc"},     pcD,           32'h0000_0000);
    check({tag, ".p4"},     PCPlus4D,      32'h0000_0000);
    check({tag, ".valid"},  {31'd0, validD}, 32'd0);
    check({tag, ".pcf2"},   imem_addr2,    32'hFFFF_FFFC);
    check({tag, ".instr2"}, instrD2,       32'h0000_0013);
  endtask

  // driver: apply one cycle of hazard inputs, queue the expected state, check after the edge
  task automatic step(input string tag,
                      input logic sf, input logic sd, input logic fd, input logic ps,
                      input logic [31:0] tgt,
                      input logic [31:0] e_pcf, input logic [31:0] e_instr,
                      input logic [31:0] e_pc, input logic [31:0] e_p4, input logic e_v);
    logic [W-1:0] e;
    stallF    = sf;
    stallD    = sd;
    flushD    = fd;
    PCSrcE    = ps;
    PCTargetE = tgt;
    exp_q.push_back({e_pcf, e_instr, e_pc, e_p4, e_v});
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".pcf"},   imem_addr,       e[128:97]);
    check({tag, ".instr"}, instrD,          e[96:65]);
    check({tag, ".pc"},    pcD,             e[64:33]);
    check({tag, ".p4"},    PCPlus4D,        e[32:1]);
    check({tag, ".valid"}, {31'd0, validD}, {31'd0, e[0]});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;
    #2;
    check_reset("reset");
    #1;
    rst = 1'b0;

    // free run from reset: 0,4,8,C; wrap instance captures 0xFFFFFFFC then wraps
    step("run0", 0, 0, 0, 0, 32'h0, 32'h04, 32'h00, 32'h00, 32'h04, 1);
    check("wrap.pcf",   imem_addr2,       32'h0000_0000);
    check("wrap.instr", instrD2,          32'hFFFF_FFFC);
    check("wrap.pc",    pcD2,             32'hFFFF_FFFC);
    check("wrap.p4",    PCPlus4D2,        32'h0000_0000);
    check("wrap.valid", {31'd0, validD2}, 32'd1);
    step("run1", 0, 0, 0, 0, 32'h0, 32'h08, 32'h04, 32'h04, 32'h08, 1);
    step("run2", 0, 0, 0, 0, 32'h0, 32'h0C, 32'h08, 32'h08, 32'h0C, 1);
    step("run3", 0, 0, 0, 0, 32'h0, 32'h10, 32'h0C, 32'h0C, 32'h10, 1);

    // restart and stall at PCF=0x8
    #2;
    rst = 1'b1;
    #1;
    check_reset("rereset");
    rst = 1'b0;
    step("pre0",   0, 0, 0, 0, 32'h0, 32'h04, 32'h00, 32'h00, 32'h04, 1);
    step("pre1",   0, 0, 0, 0, 32'h0, 32'h08, 32'h04, 32'h04, 32'h08, 1);
    step("stall0", 1, 1, 0, 0, 32'h0, 32'h08, 32'h04, 32'h04, 32'h08, 1);
    step("stall1", 1, 1, 0, 0, 32'h0, 32'h08, 32'h04, 32'h04, 32'h08, 1);
    step("resume", 0, 0, 0, 0, 32'h0, 32'h0C, 32'h08, 32'h08, 32'h0C, 1);
    step("run4",   0, 0, 0, 0, 32'h0, 32'h10, 32'h0C, 32'h0C, 32'h10, 1);

    // redirect with unaligned target, then first instruction from target
    step("redir",  0, 0, 0, 1, 32'h103, 32'h100, 32'h13, 32'h10, 32'h14, 0);
    step("tgt",    0, 0, 0, 0, 32'h0,   32'h104, 32'h100, 32'h100, 32'h104, 1);

    // every hazard input at once: redirect wins for PC, bubble in IF/ID
    step("allhaz", 1, 1, 1, 1, 32'h40, 32'h40, 32'h13, 32'h104, 32'h108, 0);
    step("tgt40",  0, 0, 0, 0, 32'h0,  32'h44, 32'h40, 32'h40,  32'h44, 1);

    // stallD with flushD: flush wins
    step("stflush", 1, 1, 1, 0, 32'h0, 32'h44, 32'h13, 32'h44, 32'h48, 0);
    step("aftfl",   0, 0, 0, 0, 32'h0, 32'h48, 32'h44, 32'h44, 32'h48, 1);

    // stallF without stallD: PC holds, IF/ID still captures
    step("sfonly",  1, 0, 0, 0, 32'h0, 32'h48, 32'h48, 32'h48, 32'h4C, 1);
    step("aftsf",   0, 0, 0, 0, 32'h0, 32'h4C, 32'h48, 32'h48, 32'h4C, 1);

    // asynchronous reset between edges while stalled and redirecting
    stallF    = 1'b1;
    stallD    = 1'b1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h200;
    #2;
    rst = 1'b1;
    #1;
    check_reset("asyncrst");
    @(negedge clk);
    #1;
    check_reset("rsthold");
    rst = 1'b0;
    step("post", 0, 0, 0, 0, 32'h0, 32'h04, 32'h00, 32'h00, 32'h04, 1);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  clock; all state updates on the falling edge, matching the other pipeline registers.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stallF  input  1  from hazard_unit; 1 = hold PC.
REQ-005 stallD  input  1  from hazard_unit; 1 = hold IF/ID register contents.
REQ-006 flushD  input  1  from hazard_unit; 1 = load bubble into IF/ID.
REQ-007 PCSrcE  input  1  from EX; 1 = taken branch/jump/jalr redirect.
REQ-008 PCTargetE  input  32  redirect target from EX.
REQ-009 imem_addr  output  32  instruction memory address; equals current PC (PCF).
REQ-010 imem_rdata  input  32  instruction word; combinational read of imem_addr.
REQ-011 instrD  output  32  instruction presented to decode.
REQ-012 pcD  output  32  PC of instrD.
REQ-013 PCPlus4D  output  32  pcD + 4.
REQ-014 validD  output  1  1 = instrD is a real fetched instruction; 0 = bubble.

Function
REQ-015 The block SHALL hold PCF internally; imem_addr SHALL equal PCF combinationally.
REQ-016 PCPlus4F SHALL be PCF + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-017 PC next-state priority SHALL be rst > PCSrcE > stallF > increment.
REQ-018 On PCSrcE=1, PCF SHALL load {PCTargetE[31:2], 2'b00} at the next falling edge, regardless of stallF.
REQ-019 On stallF=1 with PCSrcE=0, PCF SHALL hold.
REQ-020 Otherwise PCF SHALL load PCPlus4F.
REQ-021 IF/ID next-state priority SHALL be rst > (flushD or PCSrcE) > stallD > capture.
REQ-022 Bubble load: instrD=NOP_INSTR (32'h0000_0013), validD=0, pcD and PCPlus4D captured from PCF/PCPlus4F.
REQ-023 On stallD=1 with no flush or redirect, instrD, pcD, PCPlus4D and validD SHALL hold.
REQ-024 Capture: instrD=imem_rdata, pcD=PCF, PCPlus4D=PCPlus4F, validD=1.
REQ-025 Latency: an instruction at PCF SHALL appear on instrD exactly one falling edge later when unstalled.
REQ-026 Simultaneous stallD and flushD SHALL produce a bubble, so flush wins.
REQ-027 A redirect SHALL squash the in-flight IF instruction.
REQ-028 The first instruction SHALL be fetched from the target on the edge after redirect.
REQ-029 stallF=1 with stallD=0 is illegal hazard_unit output; behaviour SHALL still follow REQ-017/021 without X.

Reset
REQ-030 On rst, asynchronously: PCF=RESET_PC, instrD=NOP_INSTR, pcD=0, PCPlus4D=0, validD=0.
REQ-031 rst asserted mid-stall or mid-redirect SHALL override all other inputs immediately.
REQ-032 After rst deasserts, the first falling edge SHALL capture the instruction at RESET_PC into IF/ID.

Structure
REQ-033 NOP_INSTR and the RESET_PC default SHALL live in shared package pipe_pkg.
REQ-034 pipe_pkg SHALL be used by id_ex_reg and the other pipeline registers.
REQ-035 The PC register and its next-PC mux SHALL be a sub-module pc_reg (inputs: clk, rst, stallF, PCSrcE, PCTargetE; output: PCF).
REQ-036 The IF/ID register SHALL be inline in fetch_stage.

Verification
REQ-037 Reset, then 4 free-running cycles with ROM word = address -> instrD 0,4,8,C with validD=1 and PCPlus4D = pcD+4.
REQ-038 stallF=stallD=1 for 2 cycles at PCF=0x8 -> PCF stays 0x8 and instrD holds the word of 0x4; resume -> 0x8 appears next edge.
REQ-039 PCSrcE=1, PCTargetE=0x103 at PCF=0x10 -> next edge PCF=0x100, instrD=0x13, validD=0; following edge instrD = word at 0x100.
REQ-040 stallF=stallD=flushD=PCSrcE=1 simultaneously, target 0x40 -> PCF=0x40, bubble in IF/ID.
REQ-041 Start at RESET_PC=0xFFFF_FFFC -> next PCF=0x0, PCPlus4D=0x0 for that instruction.
REQ-042 Assert rst between edges during a stall -> outputs take reset values immediately, without waiting for a clock edge.
